// File: rtl/v_store_stream_ctrl.sv
// v_store_stream_ctrl: vector-store front end for the axim_ctrl write path.
// Takes one store request at a time, buffers the store words in a first-word-fall-through
// FIFO, starts axim_ctrl with an aligned address and byte count, streams the words out,
// and reports completion once axim_ctrl signals the write is done.
module v_store_stream_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_base_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  req_bytes,
    output logic                          req_done,
    output logic                          busy,
    input  logic                          st_tvalid,
    output logic                          st_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] st_tdata,
    output logic                          ctrl_wstart,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size,
    output logic                          wr_tvalid,
    input  logic                          wr_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata,
    input  logic                          ctrl_wdone
);

    localparam int BPB     = C_M_AXI_DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_LOW_MASK = C_M_AXI_ADDR_WIDTH'(BPB - 1);
    localparam logic [C_XFER_SIZE_WIDTH-1:0]  SIZE_LOW_MASK = C_XFER_SIZE_WIDTH'(BPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [C_XFER_SIZE_WIDTH-1:0]  beats;
    logic [C_XFER_SIZE_WIDTH-1:0]  in_cnt;
    logic [C_XFER_SIZE_WIDTH-1:0]  out_cnt;
    logic                          wdone_seen;

    logic [C_M_AXI_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;

    logic                          req_fire;
    logic                          push;
    logic                          pop;

    assign beats      = req_bytes >> LOG_BPB;
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign req_fire   = req_valid && req_ready;
    assign push       = st_tvalid && st_tready;
    assign pop        = wr_tvalid && wr_tready;
    assign busy       = (state != S_IDLE);
    assign wr_tdata   = fifo_mem[rd_ptr];

    // Next-state decode and handshake outputs for the request/stream sequencing
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        req_done    = 1'b0;
        ctrl_wstart = 1'b0;
        st_tready   = 1'b0;
        wr_tvalid   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (beats == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                ctrl_wstart = 1'b1;
                st_tready   = !fifo_full && (in_cnt != '0);
                state_next  = S_STREAM;
            end
            S_STREAM: begin
                st_tready = !fifo_full && (in_cnt != '0);
                wr_tvalid = !fifo_empty;
                if ((out_cnt == '0) ||
                    (!fifo_empty && wr_tready && (out_cnt == C_XFER_SIZE_WIDTH'(1)))) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ctrl_wdone || wdone_seen) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                req_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register, request latches, beat counters and the early-wdone flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            ctrl_waddr_offset <= '0;
            ctrl_wxfer_size   <= '0;
            in_cnt            <= '0;
            out_cnt           <= '0;
            wdone_seen        <= 1'b0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                ctrl_waddr_offset <= req_base_addr & ~ADDR_LOW_MASK;
                ctrl_wxfer_size   <= req_bytes & ~SIZE_LOW_MASK;
                in_cnt            <= beats;
                out_cnt           <= beats;
            end else begin
                if (push && (in_cnt != '0)) begin
                    in_cnt <= in_cnt - C_XFER_SIZE_WIDTH'(1);
                end
                if (pop && (out_cnt != '0)) begin
                    out_cnt <= out_cnt - C_XFER_SIZE_WIDTH'(1);
                end
            end
            if (state_next == S_IDLE) begin
                wdone_seen <= 1'b0;
            end else if (ctrl_wdone && (state != S_IDLE)) begin
                wdone_seen <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= st_tdata;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_v_store_stream_ctrl.sv
// tb_v_store_stream_ctrl: scoreboard bench for v_store_stream_ctrl with a small axim_ctrl stand-in.
module tb_v_store_stream_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int XW    = 32;
    localparam int DEPTH = 16;
    localparam int BPB   = DW / 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_base_addr;
    logic [XW-1:0] req_bytes;
    logic          req_done;
    logic          busy;
    logic          st_tvalid;
    logic          st_tready;
    logic [DW-1:0] st_tdata;
    logic          ctrl_wstart;
    logic [AW-1:0] ctrl_waddr_offset;
    logic [XW-1:0] ctrl_wxfer_size;
    logic          wr_tvalid;
    logic          wr_tready;
    logic [DW-1:0] wr_tdata;
    logic          ctrl_wdone;

    typedef struct {
        logic [AW-1:0] addr;
        logic [XW-1:0] size;
    } req_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] exp_data [$];
    logic [DW-1:0] st_src   [$];
    req_t          exp_req  [$];

    int done_cnt   = 0;
    int wstart_cnt = 0;
    int beat_cnt   = 0;
    int done_cyc   = 0;
    int wstart_cyc = 0;
    int wdone_cyc  = 0;
    int hs_cyc     = 0;
    int req_pushed = 0;
    int st_limit   = 1 << 30;
    int tready_mode = 0;
    bit coincident  = 1'b0;
    bit st_gaps     = 1'b0;
    int axi_left    = 0;
    int axi_delay   = 0;

    v_store_stream_ctrl #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_XFER_SIZE_WIDTH (XW),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_base_addr    (req_base_addr),
        .req_bytes        (req_bytes),
        .req_done         (req_done),
        .busy             (busy),
        .st_tvalid        (st_tvalid),
        .st_tready        (st_tready),
        .st_tdata         (st_tdata),
        .ctrl_wstart      (ctrl_wstart),
        .ctrl_waddr_offset(ctrl_waddr_offset),
        .ctrl_wxfer_size  (ctrl_wxfer_size),
        .wr_tvalid        (wr_tvalid),
        .wr_tready        (wr_tready),
        .wr_tdata         (wr_tdata),
        .ctrl_wdone       (ctrl_wdone)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure latencies
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Safety net in case the design stalls forever
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: pops expected words and request parameters as the DUT presents them
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_tvalid && wr_tready) begin
                    beat_cnt++;
                    if (exp_data.size() == 0) checkOutput("unexpected_beat", 1, 0);
                    else checkOutput("wr_tdata", 64'(wr_tdata), 64'(exp_data.pop_front()));
                end
                if (ctrl_wstart) begin
                    req_t r;
                    wstart_cnt++;
                    wstart_cyc = cyc;
                    checkOutput("done_with_wstart", 64'(req_done), 0);
                    if (exp_req.size() == 0) checkOutput("unexpected_wstart", 1, 0);
                    else begin
                        r = exp_req.pop_front();
                        checkOutput("waddr_offset", 64'(ctrl_waddr_offset), 64'(r.addr));
                        checkOutput("wxfer_size", 64'(ctrl_wxfer_size), 64'(r.size));
                    end
                end
                if (req_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Store-word source: offers queued words in order, then a surplus word that must never be taken
    initial begin
        st_tvalid = 1'b0;
        st_tdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst && st_tvalid && st_tready) begin
                if (st_src.size() > 0) begin
                    void'(st_src.pop_front());
                    req_pushed++;
                end else begin
                    checkOutput("surplus_accepted", 1, 0);
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                st_tvalid = 1'b0;
            end else if (st_src.size() > 0) begin
                if (req_pushed < st_limit && !(st_gaps && $urandom_range(3, 0) == 0)) begin
                    st_tvalid = 1'b1;
                    st_tdata  = st_src[0];
                end else begin
                    st_tvalid = 1'b0;
                end
            end else begin
                st_tvalid = 1'b1;
                st_tdata  = DW'($urandom);
            end
        end
    end

    // Write-side backpressure: 0 always ready, 1 random, otherwise stalled
    initial begin
        wr_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       wr_tready = 1'b1;
                1:       wr_tready = 1'($urandom_range(1, 0));
                default: wr_tready = 1'b0;
            endcase
        end
    end

    // axim_ctrl stand-in: counts beats after wstart and pulses wdone either with the last beat or later
    initial begin
        ctrl_wdone = 1'b0;
        forever begin
            @(negedge clk);
            ctrl_wdone = 1'b0;
            if (rst) begin
                axi_left  = 0;
                axi_delay = 0;
            end else if (ctrl_wstart) begin
                axi_left = int'(ctrl_wxfer_size / BPB);
            end else if (axi_left > 0 && wr_tvalid && wr_tready) begin
                axi_left--;
                if (axi_left == 0) begin
                    if (coincident) begin
                        ctrl_wdone = 1'b1;
                        wdone_cyc  = cyc;
                    end else begin
                        axi_delay = 2;
                    end
                end
            end else if (axi_delay > 0) begin
                axi_delay--;
                if (axi_delay == 0) begin
                    ctrl_wdone = 1'b1;
                    wdone_cyc  = cyc;
                end
            end
        end
    end

    // Issues one request; the reference model predicts the aligned address, size and word stream
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [XW-1:0] bytes,
                                 input bit fixed, input logic [DW-1:0] base_word);
        int beats = int'(bytes / BPB);
        logic [DW-1:0] w;
        req_t r;
        if (beats > 0) begin
            r.addr = AW'(addr - (addr % BPB));
            r.size = XW'(beats * BPB);
            exp_req.push_back(r);
        end
        for (int i = 0; i < beats; i++) begin
            w = fixed ? base_word + DW'(i) : DW'($urandom);
            exp_data.push_back(w);
            st_src.push_back(w);
        end
        req_pushed = 0;
        @(posedge clk);
        #1;
        req_valid     = 1'b1;
        req_base_addr = addr;
        req_bytes     = bytes;
        @(negedge clk);
        checkOutput("req_ready_idle", 64'(req_ready), 1);
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDone(input int start_cnt, input int budget);
        int n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("done_timeout", 64'(done_cnt == start_cnt), 0);
    endtask

    task automatic checkRequestEnd(input string tag, input int s_done, input int s_wstart, input int exp_wstart);
        checkOutput({tag, "_done_count"}, 64'(done_cnt - s_done), 1);
        checkOutput({tag, "_wstart_count"}, 64'(wstart_cnt - s_wstart), 64'(exp_wstart));
        checkOutput({tag, "_data_left"}, 64'(exp_data.size()), 0);
        checkOutput({tag, "_req_left"}, 64'(exp_req.size()), 0);
        checkOutput({tag, "_busy_after"}, 64'(busy), 0);
    endtask

    initial begin
        int s_done;
        int s_wstart;
        int s_beat;
        int n;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_base_addr = '0;
        req_bytes     = '0;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 1);
        checkOutput("rst_busy", 64'(busy), 0);
        checkOutput("rst_req_done", 64'(req_done), 0);
        checkOutput("rst_wstart", 64'(ctrl_wstart), 0);
        checkOutput("rst_st_tready", 64'(st_tready), 0);
        checkOutput("rst_wr_tvalid", 64'(wr_tvalid), 0);
        checkOutput("rst_addr", 64'(ctrl_waddr_offset), 0);
        checkOutput("rst_size", 64'(ctrl_wxfer_size), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] base transfer");
        tready_mode = 0;
        s_done = done_cnt; s_wstart = wstart_cnt;
        applyStimulus(32'h1000, 16, 1'b1, 32'hA);
        waitDone(s_done, 200);
        checkOutput("base_wstart_latency", 64'(wstart_cyc - hs_cyc), 1);
        checkOutput("base_done_latency", 64'(done_cyc - wdone_cyc), 1);
        checkRequestEnd("base", s_done, s_wstart, 1);

        $display("[TB] backpressure");
        tready_mode = 2;
        s_done = done_cnt; s_wstart = wstart_cnt; s_beat = beat_cnt;
        applyStimulus(32'h2000, XW'(4 * DEPTH * BPB), 1'b0, '0);
        n = 0;
        while (req_pushed < DEPTH && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_pushed", 64'(req_pushed), 64'(DEPTH));
        checkOutput("bp_st_tready", 64'(st_tready), 0);
        checkOutput("bp_no_beats", 64'(beat_cnt - s_beat), 0);
        tready_mode = 0;
        waitDone(s_done, 500);
        checkOutput("bp_beats", 64'(beat_cnt - s_beat), 64'(4 * DEPTH));
        checkRequestEnd("bp", s_done, s_wstart, 1);

        $display("[TB] zero bytes");
        s_done = done_cnt; s_wstart = wstart_cnt;
        applyStimulus(32'h3000, 0, 1'b0, '0);
        waitDone(s_done, 10);
        checkOutput("zero_latency", 64'(done_cyc > hs_cyc && done_cyc <= hs_cyc + 2), 1);
        checkRequestEnd("zero", s_done, s_wstart, 0);

        $display("[TB] unaligned");
        tready_mode = 1;
        s_done = done_cnt; s_wstart = wstart_cnt; s_beat = beat_cnt;
        applyStimulus(32'h1003, 9, 1'b1, 32'h100);
        waitDone(s_done, 200);
        checkOutput("unal_beats", 64'(beat_cnt - s_beat), 2);
        checkRequestEnd("unal", s_done, s_wstart, 1);

        $display("[TB] wdone with last beat");
        tready_mode = 0;
        coincident  = 1'b1;
        s_done = done_cnt; s_wstart = wstart_cnt;
        applyStimulus(32'h4000, 12, 1'b1, 32'h55);
        waitDone(s_done, 200);
        checkOutput("coin_done_latency", 64'(done_cyc - wdone_cyc), 2);
        repeat (6) @(posedge clk);
        checkRequestEnd("coin", s_done, s_wstart, 1);
        coincident = 1'b0;

        $display("[TB] random requests");
        tready_mode = 1;
        st_gaps     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [XW-1:0] b;
            coincident = 1'($urandom_range(1, 0));
            b = XW'($urandom_range(100, 0));
            s_done = done_cnt; s_wstart = wstart_cnt;
            applyStimulus(AW'($urandom), b, 1'b0, '0);
            waitDone(s_done, 2000);
            checkRequestEnd("rand", s_done, s_wstart, (b >= XW'(BPB)) ? 1 : 0);
        end
        st_gaps    = 1'b0;
        coincident = 1'b0;

        $display("[TB] reset mid-stream");
        tready_mode = 2;
        st_limit    = 5;
        s_done = done_cnt;
        applyStimulus(32'h5000, 40, 1'b0, '0);
        n = 0;
        while (req_pushed < 5 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_data.delete();
        exp_req.delete();
        st_src.delete();
        st_limit = 1 << 30;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_wr_tvalid", 64'(wr_tvalid), 0);
        checkOutput("mid_rst_busy", 64'(busy), 0);
        checkOutput("mid_rst_req_ready", 64'(req_ready), 1);
        checkOutput("mid_rst_st_tready", 64'(st_tready), 0);
        repeat (5) @(posedge clk);
        checkOutput("mid_rst_no_done", 64'(done_cnt - s_done), 0);
        tready_mode = 0;
        s_done = done_cnt; s_wstart = wstart_cnt;
        applyStimulus(32'h6000, 20, 1'b1, 32'h700);
        waitDone(s_done, 200);
        checkRequestEnd("post_rst", s_done, s_wstart, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
